// File: rtl/axi4lite_access_arbiter_pkg.sv
// Shared types for the AXI4-Lite access arbiter: FSM state encoding and response decoding.
package axi4lite_access_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ADDRESS,
        RESPONSE,
        DONE
    } axi4lite_access_arbiter_state_e;

    // BRESP/RRESP bit 1 is set for both SLVERR and DECERR
    localparam int RESP_ERROR_BIT = 1;

endpackage

// File: rtl/rggen_axi4lite_if.sv
// AXI4-Lite bundle between a bus master and the generated register block.
interface rggen_axi4lite_if #(
    parameter int ADDRESS_WIDTH = 7,
    parameter int BUS_WIDTH     = 32
);
    logic                     awvalid;
    logic                     awready;
    logic [ADDRESS_WIDTH-1:0] awaddr;
    logic [2:0]               awprot;
    logic                     wvalid;
    logic                     wready;
    logic [BUS_WIDTH-1:0]     wdata;
    logic [BUS_WIDTH/8-1:0]   wstrb;
    logic                     bvalid;
    logic                     bready;
    logic [1:0]               bresp;
    logic                     arvalid;
    logic                     arready;
    logic [ADDRESS_WIDTH-1:0] araddr;
    logic [2:0]               arprot;
    logic                     rvalid;
    logic                     rready;
    logic [BUS_WIDTH-1:0]     rdata;
    logic [1:0]               rresp;

    modport master (
        output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
        output arvalid, araddr, arprot, rready,
        input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );

    modport slave (
        input  awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
        input  arvalid, araddr, arprot, rready,
        output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );
endinterface

// File: rtl/access_rr_arbiter.sv
// Combinational round-robin pick: first requester after lastGrant_i, wrapping modulo REQUESTERS.
module access_rr_arbiter #(
    parameter int REQUESTERS  = 2,
    parameter int INDEX_WIDTH = (REQUESTERS > 1) ? $clog2(REQUESTERS) : 1
) (
    input  logic [REQUESTERS-1:0]  request_i,
    input  logic [INDEX_WIDTH-1:0] lastGrant_i,
    output logic [INDEX_WIDTH-1:0] grant_o,
    output logic                   found_o
);

    logic [INDEX_WIDTH-1:0] candidate;

    // Walk offsets from farthest to nearest so the nearest pending requester is the last write
    always_comb begin
        grant_o   = '0;
        found_o   = 1'b0;
        candidate = '0;
        for (int offset = REQUESTERS; offset >= 1; offset--) begin
            candidate = INDEX_WIDTH'((int'(lastGrant_i) + offset) % REQUESTERS);
            if (request_i[candidate]) begin
                grant_o = candidate;
                found_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/axi4lite_access_arbiter.sv
// Shares one AXI4-Lite master among several request/ack agents, one transaction at a time.
module axi4lite_access_arbiter
    import axi4lite_access_arbiter_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 7,
    parameter int BUS_WIDTH     = 32,
    parameter int REQUESTERS    = 2
) (
    input  logic                                      i_clk,
    input  logic                                      i_rst,
    input  logic [REQUESTERS-1:0]                     i_request,
    input  logic [REQUESTERS-1:0]                     i_write,
    input  logic [REQUESTERS-1:0][ADDRESS_WIDTH-1:0]  i_address,
    input  logic [REQUESTERS-1:0][BUS_WIDTH-1:0]      i_write_data,
    input  logic [REQUESTERS-1:0][BUS_WIDTH/8-1:0]    i_strobe,
    output logic [REQUESTERS-1:0]                     o_ack,
    output logic                                      o_error,
    output logic [BUS_WIDTH-1:0]                      o_read_data,
    output logic                                      o_busy,
    rggen_axi4lite_if.master                          axi4lite_if
);

    localparam int INDEX_WIDTH = (REQUESTERS > 1) ? $clog2(REQUESTERS) : 1;

    axi4lite_access_arbiter_state_e state_q;
    logic [INDEX_WIDTH-1:0]         grant_d;
    logic                           found_d;
    logic [INDEX_WIDTH-1:0]         grant_q;
    logic [INDEX_WIDTH-1:0]         lastGrant_q;
    logic                           write_q;
    logic [ADDRESS_WIDTH-1:0]       address_q;
    logic [BUS_WIDTH-1:0]           writeData_q;
    logic [BUS_WIDTH/8-1:0]         strobe_q;
    logic                           awValid_q;
    logic                           wValid_q;
    logic                           arValid_q;
    logic                           bReady_q;
    logic                           rReady_q;
    logic                           awDone_q;
    logic                           wDone_q;
    logic [REQUESTERS-1:0]          ack_q;
    logic                           error_q;
    logic [BUS_WIDTH-1:0]           readData_q;
    logic                           busy_q;
    logic                           awComplete;
    logic                           wComplete;

    access_rr_arbiter #(
        .REQUESTERS  (REQUESTERS),
        .INDEX_WIDTH (INDEX_WIDTH)
    ) u_rr_arbiter (
        .request_i   (i_request),
        .lastGrant_i (lastGrant_q),
        .grant_o     (grant_d),
        .found_o     (found_d)
    );

    // Address and data channels may complete in either order or together
    assign awComplete = awDone_q | (awValid_q & axi4lite_if.awready);
    assign wComplete  = wDone_q  | (wValid_q  & axi4lite_if.wready);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            lastGrant_q <= INDEX_WIDTH'(REQUESTERS - 1);
            write_q     <= 1'b0;
            address_q   <= '0;
            writeData_q <= '0;
            strobe_q    <= '0;
            awValid_q   <= 1'b0;
            wValid_q    <= 1'b0;
            arValid_q   <= 1'b0;
            bReady_q    <= 1'b0;
            rReady_q    <= 1'b0;
            awDone_q    <= 1'b0;
            wDone_q     <= 1'b0;
            ack_q       <= '0;
            error_q     <= 1'b0;
            readData_q  <= '0;
            busy_q      <= 1'b0;
        end else begin
            ack_q <= '0;
            case (state_q)
                IDLE: begin
                    if (found_d) begin
                        grant_q     <= grant_d;
                        write_q     <= i_write[grant_d];
                        address_q   <= i_address[grant_d];
                        writeData_q <= i_write_data[grant_d];
                        strobe_q    <= i_strobe[grant_d];
                        awValid_q   <= i_write[grant_d];
                        wValid_q    <= i_write[grant_d];
                        arValid_q   <= ~i_write[grant_d];
                        awDone_q    <= 1'b0;
                        wDone_q     <= 1'b0;
                        busy_q      <= 1'b1;
                        state_q     <= ADDRESS;
                    end
                end
                ADDRESS: begin
                    if (write_q) begin
                        if (awValid_q && axi4lite_if.awready) begin
                            awValid_q <= 1'b0;
                            awDone_q  <= 1'b1;
                        end
                        if (wValid_q && axi4lite_if.wready) begin
                            wValid_q <= 1'b0;
                            wDone_q  <= 1'b1;
                        end
                        if (awComplete && wComplete) begin
                            bReady_q <= 1'b1;
                            state_q  <= RESPONSE;
                        end
                    end else if (arValid_q && axi4lite_if.arready) begin
                        arValid_q <= 1'b0;
                        rReady_q  <= 1'b1;
                        state_q   <= RESPONSE;
                    end
                end
                RESPONSE: begin
                    if (write_q) begin
                        if (bReady_q && axi4lite_if.bvalid) begin
                            bReady_q       <= 1'b0;
                            error_q        <= axi4lite_if.bresp[RESP_ERROR_BIT];
                            ack_q[grant_q] <= 1'b1;
                            state_q        <= DONE;
                        end
                    end else if (rReady_q && axi4lite_if.rvalid) begin
                        rReady_q       <= 1'b0;
                        error_q        <= axi4lite_if.rresp[RESP_ERROR_BIT];
                        readData_q     <= axi4lite_if.rdata;
                        ack_q[grant_q] <= 1'b1;
                        state_q        <= DONE;
                    end
                end
                DONE: begin
                    lastGrant_q <= grant_q;
                    busy_q      <= 1'b0;
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign axi4lite_if.awvalid = awValid_q;
    assign axi4lite_if.awaddr  = address_q;
    assign axi4lite_if.awprot  = 3'b000;
    assign axi4lite_if.wvalid  = wValid_q;
    assign axi4lite_if.wdata   = writeData_q;
    assign axi4lite_if.wstrb   = strobe_q;
    assign axi4lite_if.bready  = bReady_q;
    assign axi4lite_if.arvalid = arValid_q;
    assign axi4lite_if.araddr  = address_q;
    assign axi4lite_if.arprot  = 3'b000;
    assign axi4lite_if.rready  = rReady_q;

    assign o_ack       = ack_q;
    assign o_error     = error_q;
    assign o_read_data = readData_q;
    assign o_busy      = busy_q;

endmodule

// File: tb/tb_axi4lite_access_arbiter.sv
// Directed bench for axi4lite_access_arbiter with a small register-block model on the AXI side.
module tb_axi4lite_access_arbiter;

    typedef struct {
        logic        wr;
        logic        req;
        logic [6:0]  addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [31:0] expRdata;
        logic        expErr;
    } vec_t;

    localparam int NVEC = 9;

    logic             clk;
    logic             rst;
    logic [1:0]       request;
    logic [1:0]       write;
    logic [1:0][6:0]  address;
    logic [1:0][31:0] writeData;
    logic [1:0][3:0]  strobe;
    logic [1:0]       ack;
    logic             error;
    logic [31:0]      readData;
    logic             busy;

    int checks;
    int passes;
    int awStall;
    int wStall;

    rggen_axi4lite_if #(.ADDRESS_WIDTH(7), .BUS_WIDTH(32)) bus ();

    axi4lite_access_arbiter #(
        .ADDRESS_WIDTH (7),
        .BUS_WIDTH     (32),
        .REQUESTERS    (2)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_request    (request),
        .i_write      (write),
        .i_address    (address),
        .i_write_data (writeData),
        .i_strobe     (strobe),
        .o_ack        (ack),
        .o_error      (error),
        .o_read_data  (readData),
        .o_busy       (busy),
        .axi4lite_if  (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Register block model: addresses below 0x60 are mapped, the rest answer SLVERR with zero data
    logic [31:0] mem [32];
    logic        bvalidR;
    logic        rvalidR;
    logic [1:0]  brespR;
    logic [1:0]  rrespR;
    logic [31:0] rdataR;
    logic        awGot;
    logic        wGot;
    int          awCnt;
    int          wCnt;
    logic [6:0]  lastAwAddr;

    function automatic logic isMapped(input logic [6:0] a);
        return a < 7'h60;
    endfunction

    assign bus.awready = bus.awvalid && (awCnt >= awStall);
    assign bus.wready  = bus.wvalid && (wCnt >= wStall);
    assign bus.arready = bus.arvalid;
    assign bus.bvalid  = bvalidR;
    assign bus.bresp   = brespR;
    assign bus.rvalid  = rvalidR;
    assign bus.rresp   = rrespR;
    assign bus.rdata   = rdataR;

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = 32'h0;
    end

    always @(posedge clk) begin
        if (rst) begin
            bvalidR <= 1'b0;
            rvalidR <= 1'b0;
            awGot   <= 1'b0;
            wGot    <= 1'b0;
            awCnt   <= 0;
            wCnt    <= 0;
        end else begin
            awCnt <= (bus.awvalid && !bus.awready) ? awCnt + 1 : 0;
            wCnt  <= (bus.wvalid && !bus.wready) ? wCnt + 1 : 0;
            if (bus.awvalid && bus.awready) begin
                awGot      <= 1'b1;
                lastAwAddr <= bus.awaddr;
            end
            if (bus.wvalid && bus.wready) wGot <= 1'b1;
            if (bvalidR && bus.bready) bvalidR <= 1'b0;
            if ((awGot || (bus.awvalid && bus.awready)) && (wGot || (bus.wvalid && bus.wready))) begin
                awGot   <= 1'b0;
                wGot    <= 1'b0;
                bvalidR <= 1'b1;
                brespR  <= isMapped(bus.awaddr) ? 2'b00 : 2'b10;
                if (isMapped(bus.awaddr)) begin
                    for (int b = 0; b < 4; b++) begin
                        if (bus.wstrb[b]) mem[bus.awaddr[6:2]][8*b +: 8] <= bus.wdata[8*b +: 8];
                    end
                end
            end
            if (rvalidR && bus.rready) rvalidR <= 1'b0;
            if (bus.arvalid && bus.arready) begin
                rvalidR <= 1'b1;
                rrespR  <= isMapped(bus.araddr) ? 2'b00 : 2'b10;
                rdataR  <= isMapped(bus.araddr) ? mem[bus.araddr[6:2]] : 32'h0;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual === expected) passes++;
        else $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, actual, expected);
    endtask

    // Issue one command at posedge+1 (arbiter idle), report what happened at the ack cycle
    task automatic applyStimulus(input vec_t v, output int latency, output logic [1:0] ackSeen,
                                 output logic errSeen, output logic [31:0] rdataSeen, output logic validsAt1);
        write[v.req]     = v.wr;
        address[v.req]   = v.addr;
        writeData[v.req] = v.wdata;
        strobe[v.req]    = v.strb;
        request[v.req]   = 1'b1;
        latency   = -1;
        ackSeen   = 2'b00;
        errSeen   = 1'b0;
        rdataSeen = 32'h0;
        validsAt1 = 1'b0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (c == 1) validsAt1 = v.wr ? (bus.awvalid && bus.wvalid) : bus.arvalid;
            if (ack != 2'b00) begin
                latency   = c;
                ackSeen   = ack;
                errSeen   = error;
                rdataSeen = readData;
                break;
            end
        end
        @(posedge clk);
        #1;
        request[v.req] = 1'b0;
    endtask

    vec_t        vecs [NVEC];
    vec_t        single;
    int          lat;
    logic [1:0]  ackV;
    logic        errV;
    logic [31:0] rdV;
    logic        v1;
    logic [1:0]  expAck;
    logic [1:0]  rrAcks [4];
    int          rrCycles [4];
    int          rrCount;
    int          ackCount;
    int          ackCycle;
    int          breadyFirst;
    logic        wvalidAt2;
    logic        awvalidAt2;
    logic        inResponse;
    logic [4:0]  handshakeLinesAfterReset;
    logic [1:0]  ackAfterReset;
    logic        busyAfterReset;
    logic [31:0] readDataAfterReset;
    logic [31:0] regrantData;

    initial begin
        vecs[0] = '{1'b1, 1'b0, 7'h00, 32'hA5A5A5A5, 4'hF, 32'h00000000, 1'b0};
        vecs[1] = '{1'b0, 1'b0, 7'h00, 32'h0,        4'h0, 32'hA5A5A5A5, 1'b0};
        vecs[2] = '{1'b1, 1'b1, 7'h10, 32'h12345678, 4'h3, 32'hA5A5A5A5, 1'b0};
        vecs[3] = '{1'b0, 1'b1, 7'h10, 32'h0,        4'h0, 32'h00005678, 1'b0};
        vecs[4] = '{1'b1, 1'b0, 7'h10, 32'hFFFFFFFF, 4'hC, 32'h00005678, 1'b0};
        vecs[5] = '{1'b0, 1'b1, 7'h10, 32'h0,        4'h0, 32'hFFFF5678, 1'b0};
        vecs[6] = '{1'b0, 1'b0, 7'h7C, 32'h0,        4'h0, 32'h00000000, 1'b1};
        vecs[7] = '{1'b0, 1'b0, 7'h00, 32'h0,        4'h0, 32'hA5A5A5A5, 1'b0};
        vecs[8] = '{1'b1, 1'b1, 7'h7C, 32'hDEADBEEF, 4'hF, 32'hA5A5A5A5, 1'b1};

        checks    = 0;
        passes    = 0;
        awStall   = 0;
        wStall    = 0;
        rst       = 1'b1;
        request   = 2'b00;
        write     = 2'b00;
        address   = '0;
        writeData = '0;
        strobe    = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        checkOutput("reset_ack", 64'(ack), 64'(2'b00));
        checkOutput("reset_error", 64'(error), 64'(1'b0));
        checkOutput("reset_read_data", 64'(readData), 64'(32'h0));
        checkOutput("reset_busy", 64'(busy), 64'(1'b0));
        checkOutput("reset_handshake_lines",
                    64'({bus.awvalid, bus.wvalid, bus.arvalid, bus.bready, bus.rready}), 64'(5'b0));

        for (int i = 0; i < NVEC; i++) begin
            applyStimulus(vecs[i], lat, ackV, errV, rdV, v1);
            expAck = 2'b00;
            expAck[vecs[i].req] = 1'b1;
            checkOutput($sformatf("vec%0d_ack", i), 64'(ackV), 64'(expAck));
            checkOutput($sformatf("vec%0d_error", i), 64'(errV), 64'(vecs[i].expErr));
            checkOutput($sformatf("vec%0d_read_data", i), 64'(rdV), 64'(vecs[i].expRdata));
            checkOutput($sformatf("vec%0d_latency", i), 64'(lat), 64'(3));
            checkOutput($sformatf("vec%0d_valids_cycle1", i), 64'(v1), 64'(1'b1));
        end

        // Both agents hold requests: last grant was 1, so grants go 0,1,0,1 every 4 cycles
        write     = 2'b11;
        address   = {7'h24, 7'h20};
        writeData = {32'h22222222, 32'h11111111};
        strobe    = {4'hF, 4'hF};
        request   = 2'b11;
        rrCount   = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (ack != 2'b00) begin
                rrAcks[rrCount]   = ack;
                rrCycles[rrCount] = c;
                rrCount++;
                if (rrCount == 4) begin
                    request = 2'b00;
                    break;
                end
            end
        end
        request = 2'b00;
        checkOutput("rr_ack_count", 64'(rrCount), 64'(4));
        if (rrCount == 4) begin
            checkOutput("rr_grant0", 64'(rrAcks[0]), 64'(2'b01));
            checkOutput("rr_grant1", 64'(rrAcks[1]), 64'(2'b10));
            checkOutput("rr_grant2", 64'(rrAcks[2]), 64'(2'b01));
            checkOutput("rr_grant3", 64'(rrAcks[3]), 64'(2'b10));
            for (int k = 1; k < 4; k++)
                checkOutput($sformatf("rr_spacing%0d", k), 64'(rrCycles[k] - rrCycles[k-1]), 64'(4));
        end
        @(posedge clk);
        #1;

        // Slave takes the data beat two cycles before the address beat
        awStall      = 2;
        write[0]     = 1'b1;
        address[0]   = 7'h30;
        writeData[0] = 32'h0BADF00D;
        strobe[0]    = 4'hF;
        request[0]   = 1'b1;
        ackCount     = 0;
        ackCycle     = -1;
        breadyFirst  = -1;
        wvalidAt2    = 1'b1;
        awvalidAt2   = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (c == 2) begin
                wvalidAt2  = bus.wvalid;
                awvalidAt2 = bus.awvalid;
            end
            if (bus.bready && breadyFirst < 0) breadyFirst = c;
            if (ack != 2'b00) begin
                ackCount++;
                ackCycle   = c;
                request[0] = 1'b0;
            end
        end
        request[0] = 1'b0;
        checkOutput("stall_wvalid_dropped", 64'(wvalidAt2), 64'(1'b0));
        checkOutput("stall_awvalid_held", 64'(awvalidAt2), 64'(1'b1));
        checkOutput("stall_bready_first_cycle", 64'(breadyFirst), 64'(4));
        checkOutput("stall_ack_count", 64'(ackCount), 64'(1));
        checkOutput("stall_ack_cycle", 64'(ackCycle), 64'(5));
        awStall = 0;
        @(posedge clk);
        #1;

        // Requester 1 changes its address after being granted; the bus must keep the sampled one
        awStall      = 2;
        write[1]     = 1'b1;
        address[1]   = 7'h40;
        writeData[1] = 32'hCAFEF00D;
        strobe[1]    = 4'hF;
        request[1]   = 1'b1;
        ackCount     = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (c == 1) address[1] = 7'h44;
            if (ack != 2'b00) begin
                ackCount++;
                break;
            end
        end
        request[1] = 1'b0;
        checkOutput("addr_change_ack_count", 64'(ackCount), 64'(1));
        checkOutput("addr_change_awaddr", 64'(lastAwAddr), 64'(7'h40));
        awStall = 0;
        @(posedge clk);
        #1;
        single = '{1'b0, 1'b1, 7'h44, 32'h0, 4'h0, 32'h0, 1'b0};
        applyStimulus(single, lat, ackV, errV, rdV, v1);
        checkOutput("addr_change_0x44_untouched", 64'(rdV), 64'(32'h0));
        single = '{1'b0, 1'b1, 7'h40, 32'h0, 4'h0, 32'h0, 1'b0};
        applyStimulus(single, lat, ackV, errV, rdV, v1);
        checkOutput("addr_change_0x40_written", 64'(rdV), 64'(32'hCAFEF00D));

        // Reset lands while a read sits in RESPONSE; requester keeps asking and is served again
        write[1]   = 1'b0;
        address[1] = 7'h00;
        request[1] = 1'b1;
        inResponse = 1'b0;
        handshakeLinesAfterReset = 5'h1F;
        ackAfterReset      = 2'b11;
        busyAfterReset     = 1'b1;
        readDataAfterReset = 32'hFFFFFFFF;
        ackCycle    = -1;
        ackV        = 2'b00;
        regrantData = 32'h0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (c == 2) begin
                inResponse = bus.rready;
                rst = 1'b1;
            end else if (c == 3) begin
                handshakeLinesAfterReset = {bus.awvalid, bus.wvalid, bus.arvalid, bus.bready, bus.rready};
                ackAfterReset      = ack;
                busyAfterReset     = busy;
                readDataAfterReset = readData;
                rst = 1'b0;
            end else if (c > 3 && ack != 2'b00) begin
                ackCycle    = c;
                ackV        = ack;
                regrantData = readData;
                break;
            end
        end
        request[1] = 1'b0;
        rst = 1'b0;
        checkOutput("rst_precondition_response", 64'(inResponse), 64'(1'b1));
        checkOutput("rst_handshake_lines", 64'(handshakeLinesAfterReset), 64'(5'b0));
        checkOutput("rst_ack", 64'(ackAfterReset), 64'(2'b00));
        checkOutput("rst_busy", 64'(busyAfterReset), 64'(1'b0));
        checkOutput("rst_read_data", 64'(readDataAfterReset), 64'(32'h0));
        checkOutput("rst_regrant_ack", 64'(ackV), 64'(2'b10));
        checkOutput("rst_regrant_cycle", 64'(ackCycle), 64'(6));
        checkOutput("rst_regrant_data", 64'(regrantData), 64'(32'hA5A5A5A5));

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
